// File: rtl/mandelbrot_iter_engine.sv
// rtl/mandelbrot_iter_engine.sv - Mandelbrot per-pixel iteration engine
//
// Iterates z := z^2 + c in signed fixed point (Q(WIDTH-FRAC).FRAC), one
// iteration per clock, until |z|^2 > 4.0 or the iteration limit is reached.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   in_valid / in_ready   job handshake; c_re, c_im, max_iter, in_tag sampled
//                         on acceptance
//   out_valid / out_ready result handshake; iter, escaped, out_tag held
//                         stable while out_valid && !out_ready
module mandelbrot_iter_engine #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 28,
    parameter int TAG_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    input  logic        [7:0]       max_iter,
    input  logic        [TAG_W-1:0] in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [7:0]       iter,
    output logic                    escaped,
    output logic        [TAG_W-1:0] out_tag
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;

    // 4.0 expressed at the scale of a full-precision product (2*FRAC fraction bits)
    localparam logic [EW-1:0] ESC_LIM = {{(EW-3){1'b0}}, 3'b100} << (2 * FRAC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] zr_q, zr_d;
    logic signed [WIDTH-1:0] zi_q, zi_d;
    logic signed [WIDTH-1:0] cr_q, cr_d;
    logic signed [WIDTH-1:0] ci_q, ci_d;
    logic        [7:0]       n_q, n_d;
    logic        [7:0]       lim_q, lim_d;
    logic        [TAG_W-1:0] tag_q, tag_d;
    logic        [7:0]       iter_q, iter_d;
    logic                    esc_q, esc_d;
    // The result registers settle on the DONE entry edge; out_valid is raised
    // one edge later so the presented result always comes straight from flops.
    logic                    show_q, show_d;

    logic signed [PW-1:0] zr_x, zi_x;
    logic signed [PW-1:0] rr, ii, ri;
    logic        [EW-1:0] mag;
    logic signed [EW-1:0] diff, twori;
    logic signed [WIDTH-1:0] zr_next, zi_next;
    logic                 escape, at_limit;

    // Datapath: full-precision products and escape test
    assign zr_x = {{WIDTH{zr_q[WIDTH-1]}}, zr_q};
    assign zi_x = {{WIDTH{zi_q[WIDTH-1]}}, zi_q};
    assign rr   = zr_x * zr_x;
    assign ii   = zi_x * zi_x;
    assign ri   = zr_x * zi_x;

    // rr and ii are non-negative, so the sum is formed unsigned with one guard bit
    assign mag      = {1'b0, rr} + {1'b0, ii};
    assign escape   = (mag > ESC_LIM);
    assign at_limit = (n_q == lim_q);

    // Differences and doubling kept one bit wider so nothing is lost before the shift
    assign diff    = {rr[PW-1], rr} - {ii[PW-1], ii};
    assign twori   = {ri, 1'b0};
    assign zr_next = WIDTH'(diff >>> FRAC) + cr_q;
    assign zi_next = WIDTH'(twori >>> FRAC) + ci_q;

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ITER;
            ITER:    if (escape || at_limit) state_d = DONE;
            DONE:    if (show_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE) && show_q;
    end

    // Datapath next state
    always_comb begin
        zr_d   = zr_q;
        zi_d   = zi_q;
        cr_d   = cr_q;
        ci_d   = ci_q;
        n_d    = n_q;
        lim_d  = lim_q;
        tag_d  = tag_q;
        iter_d = iter_q;
        esc_d  = esc_q;
        show_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cr_d  = c_re;
                    ci_d  = c_im;
                    lim_d = max_iter;
                    tag_d = in_tag;
                    zr_d  = '0;
                    zi_d  = '0;
                    n_d   = '0;
                end
            end
            ITER: begin
                if (escape) begin
                    iter_d = n_q;
                    esc_d  = 1'b1;
                end else if (at_limit) begin
                    iter_d = n_q;
                    esc_d  = 1'b0;
                end else begin
                    zr_d = zr_next;
                    zi_d = zi_next;
                    n_d  = n_q + 8'd1;
                end
            end
            DONE: begin
                show_d = !(show_q && out_ready);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zr_q   <= '0;
            zi_q   <= '0;
            cr_q   <= '0;
            ci_q   <= '0;
            n_q    <= '0;
            lim_q  <= '0;
            tag_q  <= '0;
            iter_q <= '0;
            esc_q  <= 1'b0;
            show_q <= 1'b0;
        end else begin
            zr_q   <= zr_d;
            zi_q   <= zi_d;
            cr_q   <= cr_d;
            ci_q   <= ci_d;
            n_q    <= n_d;
            lim_q  <= lim_d;
            tag_q  <= tag_d;
            iter_q <= iter_d;
            esc_q  <= esc_d;
            show_q <= show_d;
        end
    end

    assign iter    = iter_q;
    assign escaped = esc_q;
    assign out_tag = tag_q;

endmodule
